// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter: one grant at a time, held until done or request drop.
// Optional forced release after TIMEOUT_CYCLES is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arbiter4 #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] win_idx;
    logic       win_found;
    logic       rel_normal;
    logic       force_rel;

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_param_check
            $error("rr_arbiter4: TIMEOUT_CYCLES must be >= 2");
        end
    endgenerate

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            if (!win_found && req[ptr_q + 2'(i)]) begin
                win_found = 1'b1;
                win_idx   = ptr_q + 2'(i);
            end
        end
    end

    assign rel_normal = (state_q == BUSY) && (done || !req[idx_q]);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    idx_d   = win_idx;
                end
            end
            BUSY: begin
                if (rel_normal || force_rel) begin
                    state_d = IDLE;
                    ptr_d   = idx_q + 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = (state_d == BUSY) ? (4'b0001 << idx_d) : 4'b0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            gnt_q   <= 4'b0000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = idx_q;
    assign gnt_vld = (state_q == BUSY);

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    // Counter sits at zero in IDLE, so the first visible grant cycle counts as zero.
    always_comb begin
        hold_cnt_d = (state_q == BUSY) ? hold_cnt_q + CNT_W'(1) : '0;
        if (state_d == IDLE) begin
            hold_cnt_d = '0;
        end
    end

    assign force_rel = (state_q == BUSY) && (hold_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign timeout_d = force_rel && !rel_normal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule
